// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one outstanding load/store, size/offset lane steering, bus timeout.
// Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them down.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  output logic [63:0] load_data,
  output logic        load_re,
  output logic [2:0]  load_func3,
  output logic        misalign_fault,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'b00:   align_off = off;
      2'b01:   align_off = {off[2:1], 1'b0};
      2'b10:   align_off = {off[2], 2'b00};
      default: align_off = 3'b000;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    misaligned = (off != align_off(off, sz));
  endfunction
`endif

  state_t      state_q;
  logic        re_q, we_q;
  logic [2:0]  func3_q;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic        resp_valid_q;
  logic [63:0] load_data_q;
  logic        load_re_q;
  logic [2:0]  load_func3_q;
  logic        misalign_q;
  logic        bus_err_q;

  logic [2:0]  off_d;
  logic [7:0]  cnt_d;
  logic        timeout_d;
  logic        misalign_d;
  logic [63:0] rdata_sh_d;

  // Offset of the in-flight access, already forced to its natural alignment.
  assign off_d      = align_off(addr_q[2:0], func3_q[1:0]);
  assign cnt_d      = cnt_q + 8'd1;
  assign timeout_d  = (cnt_d == TIMEOUT_L);
  assign rdata_sh_d = mem_rdata >> {off_d, 3'b000};
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_d = misaligned(addr[2:0], func3[1:0]);
`else
  assign misalign_d = 1'b0;
`endif

  assign req_ready      = (state_q == IDLE);
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_req_q & we_q;
  assign mem_addr       = {addr_q[63:3], 3'b000};
  assign mem_wstrb      = mem_we ? (size_mask(func3_q[1:0]) << off_d) : 8'h00;
  assign mem_wdata      = mem_we ? (wdata_q << {off_d, 3'b000}) : 64'd0;
  assign resp_valid     = resp_valid_q;
  assign load_data      = load_data_q;
  assign load_re        = load_re_q;
  assign load_func3     = load_func3_q;
  assign misalign_fault = misalign_q;
  assign bus_err        = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      func3_q      <= 3'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      load_data_q  <= 64'd0;
      load_re_q    <= 1'b0;
      load_func3_q <= 3'd0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A request with neither re nor we is consumed here and never reaches memory.
          if (req_valid && (re || we)) begin
            re_q    <= re;
            we_q    <= we;
            func3_q <= func3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 8'd0;
            if (misalign_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              load_re_q    <= re & ~we;
              load_func3_q <= func3;
              load_data_q  <= 64'd0;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_d;
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              load_re_q    <= 1'b0;
              load_func3_q <= func3_q;
              load_data_q  <= 64'd0;
            end else begin
              state_q <= WAIT;
            end
          end else if (timeout_d) begin
            mem_req_q    <= 1'b0;
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            bus_err_q    <= 1'b1;
            load_re_q    <= re_q & ~we_q;
            load_func3_q <= func3_q;
            load_data_q  <= 64'd0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_d;
          if (mem_rvalid) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            load_re_q    <= re_q & ~we_q;
            load_func3_q <= func3_q;
            load_data_q  <= rdata_sh_d;
          end else if (timeout_d) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            bus_err_q    <= 1'b1;
            load_re_q    <= re_q & ~we_q;
            load_func3_q <= func3_q;
            load_data_q  <= 64'd0;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          bus_err_q    <= 1'b0;
          load_re_q    <= 1'b0;
          load_func3_q <= 3'd0;
          load_data_q  <= 64'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
